// File: rtl/byte_serial_mem_ctrl.sv
// Byte-serial memory controller with an internal byte-wide array.
// Each access moves one byte per clock between the array and a 64-bit little-endian register.
module byte_serial_mem_ctrl #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [2:0]            operation,
  input  logic [63:0]           write_data,
  output logic                  status,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] address_to_rw,
  output logic [63:0]           data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACTIVE = 2'b01,
    S_READ   = 2'b10,
    S_WRITE  = 2'b11
  } state_t;

  localparam logic [2:0] OP_READ_D = 3'b001;
  localparam logic [2:0] OP_READ_W = 3'b010;
  localparam logic [2:0] OP_READ_H = 3'b011;
  localparam logic [2:0] OP_READ_B = 3'b100;
  localparam logic [2:0] OP_WRITE  = 3'b111;

  logic [7:0]            r_mem [0:(1<<ADDR_WIDTH)-1];
  state_t                r_state;
  logic [15:0]           r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_op;
  logic [63:0]           r_wdata;
  logic [63:0]           r_data;
  logic                  r_status;
  logic                  r_mem_read;
  logic                  r_mem_write;

  logic                  w_op_valid;
  logic [2:0]            w_byte_idx;
  logic [ADDR_WIDTH-1:0] w_addr_rw;
  logic [7:0]            w_rd_byte;
  logic [7:0]            w_wr_byte;

  function automatic logic [15:0] len_of(input logic [2:0] op);
    case (op)
      OP_READ_D, OP_WRITE: len_of = 16'd8;
      OP_READ_W:           len_of = 16'd4;
      OP_READ_H:           len_of = 16'd2;
      OP_READ_B:           len_of = 16'd1;
      default:             len_of = 16'd0;
    endcase
  endfunction

  // Reserved codes and NOP both have zero length, so they never leave IDLE.
  assign w_op_valid = (len_of(operation) != 16'd0);
  assign w_byte_idx = r_cnt[2:0] - 3'd1;
  assign w_addr_rw  = r_addr + ADDR_WIDTH'(r_cnt) - ADDR_WIDTH'(1);
  assign w_rd_byte  = r_mem[w_addr_rw];
  assign w_wr_byte  = r_wdata[{w_byte_idx, 3'b000} +: 8];

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_op        <= '0;
      r_wdata     <= '0;
      r_data      <= '0;
      r_status    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_op_valid) begin
            r_addr   <= address;
            r_op     <= operation;
            r_wdata  <= write_data;
            r_state  <= S_ACTIVE;
            r_status <= 1'b1;
          end
        end
        S_ACTIVE: begin
          r_cnt <= len_of(r_op);
          if (r_op == OP_WRITE) begin
            r_state     <= S_WRITE;
            r_mem_write <= 1'b1;
          end else begin
            r_state    <= S_READ;
            r_mem_read <= 1'b1;
            r_data     <= '0;
          end
        end
        S_READ: begin
          if (r_cnt != 16'd0) begin
            r_data[{w_byte_idx, 3'b000} +: 8] <= w_rd_byte;
            r_cnt      <= r_cnt - 16'd1;
            r_mem_read <= (r_cnt != 16'd1);
          end else begin
            r_state  <= S_IDLE;
            r_status <= 1'b0;
          end
        end
        S_WRITE: begin
          if (r_cnt != 16'd0) begin
            r_cnt       <= r_cnt - 16'd1;
            r_mem_write <= (r_cnt != 16'd1);
          end else begin
            r_state  <= S_IDLE;
            r_status <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; a reset edge only suppresses the write pending on that edge.
  always_ff @(posedge clk) begin
    if (rst_n && r_mem_write) r_mem[w_addr_rw] <= w_wr_byte;
  end

  assign status        = r_status;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign address_to_rw = w_addr_rw;
  assign data          = r_data;

endmodule

// File: tb/tb_byte_serial_mem_ctrl.sv
// Scoreboard bench for byte_serial_mem_ctrl: the driver queues expected results,
// a negedge monitor checks stall length, strobes, address sequence and data per access.
module tb_byte_serial_mem_ctrl;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_READ_D = 3'b001;
  localparam logic [2:0] OP_READ_W = 3'b010;
  localparam logic [2:0] OP_READ_H = 3'b011;
  localparam logic [2:0] OP_READ_B = 3'b100;
  localparam logic [2:0] OP_WRITE  = 3'b111;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [2:0]  op;
    logic [19:0] addr;
    logic [63:0] data;
    logic [63:0] mask;
    int          stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] address = '0;
  logic [2:0]  operation = OP_NOP;
  logic [63:0] write_data = '0;
  logic        status, mem_read, mem_write;
  logic [19:0] address_to_rw;
  logic [63:0] data;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  byte_serial_mem_ctrl #(.ADDR_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .operation(operation),
    .write_data(write_data), .status(status), .mem_read(mem_read),
    .mem_write(mem_write), .address_to_rw(address_to_rw), .data(data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one transaction spans the negedges where status is high.
  exp_t        cur;
  bit          in_txn = 0;
  int          stall_cnt, rd_cnt, wr_cnt;
  bit          addr_ok;
  logic [19:0] nxt_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn = 0;
    end else if (status) begin
      if (!in_txn) begin
        if (exp_q.size() == 0) begin
          check("unexpected_busy", 64'(status), 64'd0);
        end else begin
          cur       = exp_q.pop_front();
          in_txn    = 1;
          stall_cnt = 0;
          rd_cnt    = 0;
          wr_cnt    = 0;
          addr_ok   = 1;
          nxt_addr  = cur.addr + 20'(cur.stall - 3);
        end
      end
      if (in_txn) begin
        stall_cnt++;
        if (mem_read || mem_write) begin
          if (address_to_rw !== nxt_addr) addr_ok = 0;
          nxt_addr = nxt_addr - 20'd1;
          if (mem_read) rd_cnt++;
          if (mem_write) wr_cnt++;
        end
      end
    end else if (in_txn) begin
      in_txn = 0;
      check("stall_cycles", 64'(stall_cnt), 64'(cur.stall));
      check("read_strobes", 64'(rd_cnt), (cur.op == OP_WRITE) ? 64'd0 : 64'(cur.stall - 2));
      check("write_strobes", 64'(wr_cnt), (cur.op == OP_WRITE) ? 64'd8 : 64'd0);
      check("addr_sequence", 64'(addr_ok), 64'd1);
      check("data", data & cur.mask, cur.data & cur.mask);
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!status) done = 1;
    end
    if (!done) check("idle_timeout", 64'(status), 64'd0);
  endtask

  task automatic push(input logic [2:0] op, input logic [19:0] addr, input logic [63:0] exp_d,
                      input logic [63:0] mask, input int stall);
    exp_t e;
    e.op = op; e.addr = addr; e.data = exp_d; e.mask = mask; e.stall = stall;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [19:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_d, input logic [63:0] mask, input int stall);
    push(op, addr, exp_d, mask, stall);
    @(posedge clk); #1;
    operation = op; address = addr; write_data = wd;
    @(posedge clk); #1;
    operation = OP_NOP;
    wait_idle();
  endtask

  task automatic nop_check(input logic [2:0] op, input logic [63:0] exp_d);
    bit quiet = 1;
    @(posedge clk); #1;
    operation = op; address = 20'h00010; write_data = ALL;
    @(posedge clk); #1;
    operation = OP_NOP;
    repeat (3) begin
      @(negedge clk);
      if (status || mem_read || mem_write) quiet = 0;
    end
    check("nop_quiet", 64'(quiet), 64'd1);
    check("nop_data", data, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_status", 64'(status), 64'd0);
    check("reset_data", data, 64'd0);
    check("reset_strobes", 64'({mem_read, mem_write}), 64'd0);

    run_op(OP_WRITE,  20'h00010, 64'h1122334455667788, 64'h0, ALL, 10);
    run_op(OP_READ_D, 20'h00010, 64'h0, 64'h1122334455667788, ALL, 10);
    run_op(OP_READ_W, 20'h00010, 64'h0, 64'h0000000055667788, ALL, 6);
    run_op(OP_READ_H, 20'h00010, 64'h0, 64'h0000000000007788, ALL, 4);
    run_op(OP_READ_B, 20'h00010, 64'h0, 64'h0000000000000088, ALL, 3);

    nop_check(OP_NOP,  64'h88);
    nop_check(3'b101,  64'h88);
    nop_check(3'b110,  64'h88);

    // Wrapping write: bytes land at 0xFFFFC..0xFFFFF then 0x00000..0x00003.
    run_op(OP_WRITE,  20'hFFFFC, 64'hDEADBEEFCAFEF00D, 64'h88, ALL, 10);
    run_op(OP_READ_D, 20'hFFFFC, 64'h0, 64'hDEADBEEFCAFEF00D, ALL, 10);
    run_op(OP_READ_W, 20'h00000, 64'h0, 64'h00000000DEADBEEF, ALL, 6);

    // Back-to-back: second op is held through the first and must be taken in the first IDLE cycle.
    push(OP_READ_B, 20'h00017, 64'h11, ALL, 3);
    push(OP_READ_H, 20'h00016, 64'h1122, ALL, 4);
    @(posedge clk); #1;
    operation = OP_READ_B; address = 20'h00017;
    @(posedge clk); #1;
    operation = OP_READ_H; address = 20'h00016;
    wait_idle();
    @(posedge clk); #1;
    operation = OP_NOP;
    wait_idle();

    run_op(OP_WRITE,  20'h00020, 64'hA0A1A2A3A4A5A6A7, 64'h1122, ALL, 10);
    run_op(OP_READ_D, 20'h00020, 64'h0, 64'hA0A1A2A3A4A5A6A7, ALL, 10);

    // Reset in the 4th busy cycle of a write: only 0x27 and 0x26 have been written.
    push(OP_WRITE, 20'h00020, 64'h0, ALL, 10);
    @(posedge clk); #1;
    operation = OP_WRITE; address = 20'h00020; write_data = 64'h0102030405060708;
    @(posedge clk); #1;
    operation = OP_NOP;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_status", 64'(status), 64'd0);
    check("abort_strobes", 64'({mem_read, mem_write}), 64'd0);
    check("abort_cnt", 64'(dut.r_cnt), 64'd0);
    check("abort_data", data, 64'd0);
    run_op(OP_READ_D, 20'h00020, 64'h0, 64'h010200A3A4A5A6A7, 64'hFFFF00FFFFFFFFFF, 10);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
